// File: rtl/sindoku_checker.sv
// sindoku_checker: grades a 9x9 player grid against the stored solution.
// The grid is read in row-major order through a read port with 1-cycle latency.
// The checker counts empty cells and wrong entries, and records the first
// wrong cell. It hands a verdict back to the game FSM with a Start/Ack handshake.
module sindoku_checker #(
    parameter int N  = 9,
    parameter int VW = 4,
    parameter int CW = 7
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          CEN,
    input  logic          Start,
    input  logic          Ack,
    output logic [3:0]    rd_row,
    output logic [3:0]    rd_col,
    input  logic [VW-1:0] cell_val,
    input  logic [VW-1:0] sol_val,
    output logic [CW-1:0] ErrCount,
    output logic [CW-1:0] EmptyCount,
    output logic          ErrFound,
    output logic [3:0]    FirstErrRow,
    output logic [3:0]    FirstErrCol,
    output logic          Solved,
    output logic          q_Idle,
    output logic          q_Scan,
    output logic          q_Flush,
    output logic          q_Done
);

    // One-hot encoding, so that any corrupted state pattern is detectable and recoverable.
    typedef enum logic [3:0] {
        S_IDLE  = 4'b0001,
        S_SCAN  = 4'b0010,
        S_FLUSH = 4'b0100,
        S_DONE  = 4'b1000
    } state_t;

    localparam logic [3:0]    LAST = 4'(N - 1);
    localparam logic [CW-1:0] CMAX = '1;

    state_t state, next_state;

    // Address of the cell whose data is currently on cell_val/sol_val.
    logic [3:0] cmp_row, cmp_col;
    // Set once cmp_row/cmp_col refer to a real issued address.
    logic       pend_valid;

    logic clear, step, compare;
    logic is_empty, is_wrong;

    assign is_empty = (cell_val == '0);
    assign is_wrong = !is_empty && (cell_val != sol_val);

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state <= S_IDLE;
        else
            state <= next_state;
    end

    // Next-state logic and per-cycle control strobes for the datapath.
    always_comb begin
        next_state = state;
        clear      = 1'b0;
        step       = 1'b0;
        compare    = 1'b0;
        case (state)
            S_IDLE: begin
                if (Start) begin
                    clear      = 1'b1;
                    next_state = S_SCAN;
                end
            end
            S_SCAN: begin
                if (CEN) begin
                    step    = 1'b1;
                    compare = pend_valid;
                    if (rd_row == LAST && rd_col == LAST)
                        next_state = S_FLUSH;
                end
            end
            S_FLUSH: begin
                if (CEN) begin
                    compare    = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (Ack)
                    next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Address generator and one-stage pipeline tracking which cell the read data belongs to.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rd_row     <= '0;
            rd_col     <= '0;
            cmp_row    <= '0;
            cmp_col    <= '0;
            pend_valid <= 1'b0;
        end else if (clear) begin
            rd_row     <= '0;
            rd_col     <= '0;
            cmp_row    <= '0;
            cmp_col    <= '0;
            pend_valid <= 1'b0;
        end else if (step) begin
            cmp_row    <= rd_row;
            cmp_col    <= rd_col;
            pend_valid <= 1'b1;
            if (rd_col == LAST) begin
                // The address stops on the final cell so that it never leaves the grid.
                if (rd_row != LAST) begin
                    rd_col <= '0;
                    rd_row <= rd_row + 4'd1;
                end
            end else begin
                rd_col <= rd_col + 4'd1;
            end
        end
    end

    // Result accumulation: saturating counters and capture of the first wrong cell.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ErrCount    <= '0;
            EmptyCount  <= '0;
            ErrFound    <= 1'b0;
            FirstErrRow <= '0;
            FirstErrCol <= '0;
        end else if (clear) begin
            ErrCount    <= '0;
            EmptyCount  <= '0;
            ErrFound    <= 1'b0;
            FirstErrRow <= '0;
            FirstErrCol <= '0;
        end else if (compare) begin
            if (is_empty && EmptyCount != CMAX)
                EmptyCount <= EmptyCount + 1'b1;
            if (is_wrong) begin
                if (ErrCount != CMAX)
                    ErrCount <= ErrCount + 1'b1;
                if (!ErrFound) begin
                    ErrFound    <= 1'b1;
                    FirstErrRow <= cmp_row;
                    FirstErrCol <= cmp_col;
                end
            end
        end
    end

    assign Solved  = (state == S_DONE) && (ErrCount == '0) && (EmptyCount == '0);
    assign q_Idle  = (state == S_IDLE);
    assign q_Scan  = (state == S_SCAN);
    assign q_Flush = (state == S_FLUSH);
    assign q_Done  = (state == S_DONE);

endmodule
